// File: rtl/alu_issue_seq_pkg.sv
// alu_issue_seq_pkg: shared opcodes, FSM state encoding and opcode legality for alu_issue_seq
// Optional feature macro: LOAD_IMM_EN (adds LDI rd, imm8 as opcode 4'h8)
package alu_issue_seq_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h8;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;
  // NOP counts as legal: it issues normally but never writes back.
  function automatic logic op_legal(input logic [3:0] op);
`ifdef LOAD_IMM_EN
    return (op <= OP_XOR) || (op == OP_LDI);
`else
    return op <= OP_XOR;
`endif
  endfunction
endpackage

// File: rtl/alu_issue_seq_reg_file.sv
// alu_issue_seq_reg_file: NREG x WIDTH register file, r0 hardwired to zero
// Ports: clk, res (async active-low clear), i_raddr1/i_raddr2/i_dbg_raddr (combinational reads),
//        i_we/i_waddr/i_wdata (synchronous write), o_rdata1/o_rdata2/o_dbg_rdata
module alu_issue_seq_reg_file #(
  parameter int NREG  = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic [3:0]       i_raddr1,
  input  logic [3:0]       i_raddr2,
  input  logic [3:0]       i_dbg_raddr,
  input  logic             i_we,
  input  logic [3:0]       i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata1,
  output logic [WIDTH-1:0] o_rdata2,
  output logic [WIDTH-1:0] o_dbg_rdata
);
  logic [WIDTH-1:0] r_mem [NREG];
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we && i_waddr != 4'd0) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end
  assign o_rdata1    = (i_raddr1 == 4'd0) ? '0 : r_mem[i_raddr1];
  assign o_rdata2    = (i_raddr2 == 4'd0) ? '0 : r_mem[i_raddr2];
  assign o_dbg_rdata = (i_dbg_raddr == 4'd0) ? '0 : r_mem[i_dbg_raddr];
endmodule

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: serial issue/writeback sequencer feeding the alu stage (IDLE -> EXEC -> WB)
// Ports: clk, res (async active-low reset), instr_in/instr_valid/instr_ready (instruction handshake),
//        Lbus/Rbus/OP (registered alu operands/opcode), Obus (alu result), wb_en/wb_addr/wb_data
//        (writeback), err (illegal-opcode pulse in WB), dbg_raddr/dbg_rdata (debug register read)
// Optional feature macro: LOAD_IMM_EN (LDI rd, imm8 issued as ADD 0 + imm8)
module alu_issue_seq
  import alu_issue_seq_pkg::*;
#(
  parameter int NREG  = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic [15:0]      instr_in,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [WIDTH-1:0] Lbus,
  output logic [WIDTH-1:0] Rbus,
  output logic [3:0]       OP,
  input  logic [WIDTH-1:0] Obus,
  output logic             wb_en,
  output logic [3:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             err,
  input  logic [3:0]       dbg_raddr,
  output logic [WIDTH-1:0] dbg_rdata
);
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_lbus, r_rbus;
  logic [3:0]       r_op, r_rd;
  logic             r_legal, r_nop;
  logic [WIDTH-1:0] w_rdata1, w_rdata2, w_lbus_nxt, w_rbus_nxt;
  logic [3:0]       w_opc, w_op_nxt;
  logic             w_accept, w_legal, w_ldi;
  assign w_opc    = instr_in[15:12];
  assign w_legal  = op_legal(w_opc);
`ifdef LOAD_IMM_EN
  assign w_ldi    = w_opc == OP_LDI;
`else
  assign w_ldi    = 1'b0;
`endif
  assign w_accept = instr_valid && instr_ready;
  // LDI reuses the alu adder: 0 + zero-extended imm8.
  assign w_lbus_nxt = w_ldi ? '0 : w_rdata1;
  assign w_rbus_nxt = w_ldi ? {{(WIDTH-8){1'b0}}, instr_in[7:0]} : w_rdata2;
  assign w_op_nxt   = w_ldi ? OP_ADD : (w_legal ? w_opc : OP_NOP);
  always_ff @(posedge clk or negedge res) begin
    if (!res) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = ST_IDLE;
    instr_ready = 1'b0;
    wb_en       = 1'b0;
    err         = 1'b0;
    wb_addr     = r_rd;
    wb_data     = Obus;
    w_state_nxt = (r_state == ST_IDLE) ? (w_accept ? ST_EXEC : ST_IDLE) :
                  (r_state == ST_EXEC) ? ST_WB : ST_IDLE;
    instr_ready = res && (r_state == ST_IDLE);
    wb_en       = (r_state == ST_WB) && r_legal && !r_nop && (r_rd != 4'd0);
    err         = (r_state == ST_WB) && !r_legal;
  end
  // OP is non-NOP only for the single cycle following an accept (EXEC).
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_lbus  <= '0;
      r_rbus  <= '0;
      r_op    <= OP_NOP;
      r_rd    <= 4'd0;
      r_legal <= 1'b0;
      r_nop   <= 1'b0;
    end else if (w_accept) begin
      r_lbus  <= w_lbus_nxt;
      r_rbus  <= w_rbus_nxt;
      r_op    <= w_op_nxt;
      r_rd    <= instr_in[11:8];
      r_legal <= w_legal;
      r_nop   <= w_opc == OP_NOP;
    end else begin
      r_op    <= OP_NOP;
    end
  end
  assign Lbus = r_lbus;
  assign Rbus = r_rbus;
  assign OP   = r_op;
  alu_issue_seq_reg_file #(
    .NREG (NREG),
    .WIDTH(WIDTH)
  ) u_rf (
    .clk        (clk),
    .res        (res),
    .i_raddr1   (instr_in[7:4]),
    .i_raddr2   (instr_in[3:0]),
    .i_dbg_raddr(dbg_raddr),
    .i_we       (wb_en),
    .i_waddr    (r_rd),
    .i_wdata    (Obus),
    .o_rdata1   (w_rdata1),
    .o_rdata2   (w_rdata2),
    .o_dbg_rdata(dbg_rdata)
  );
endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: randomized self-checking bench for alu_issue_seq with a behavioural alu and register model
module tb_alu_issue_seq;
`ifdef LOAD_IMM_EN
  localparam bit LDI_ON = 1'b1;
`else
  localparam bit LDI_ON = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic [15:0] instr_in = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] Lbus, Rbus, wb_data, dbg_rdata;
  logic [3:0]  OP, wb_addr;
  logic [3:0]  dbg_raddr = '0;
  logic [15:0] Obus = '0;
  logic        wb_en, err;
  logic        seed_en = 1'b0;
  logic [15:0] seed_val = '0;
  logic [15:0] m_rf [16];
  int          n_chk = 0;
  int          n_fail = 0;

  alu_issue_seq dut (
    .clk        (clk),
    .res        (res),
    .instr_in   (instr_in),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .Lbus       (Lbus),
    .Rbus       (Rbus),
    .OP         (OP),
    .Obus       (Obus),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .err        (err),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata)
  );

  always #5 clk = ~clk;

  // Stand-in alu: registers its result one edge after OP; seed mode forces a chosen result.
  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'h1:    return a + b;
      4'h2:    return a - b;
      4'h3:    return a & b;
      4'h4:    return a | b;
      4'h5:    return a ^ b;
      default: return 16'h0000;
    endcase
  endfunction
  always @(posedge clk) Obus <= seed_en ? seed_val : alu_f(OP, Lbus, Rbus);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic peek(input logic [3:0] a, input logic [15:0] exp, input string tag);
    dbg_raddr = a;
    #1;
    chk(tag, dbg_rdata, exp);
  endtask

  // Called just after a negedge with the DUT in IDLE; returns just after the negedge of the following IDLE.
  task automatic issue(input logic [15:0] ins, input bit keep_valid);
    logic [3:0]  opc, rd, rs1, rs2;
    logic [7:0]  imm;
    logic [15:0] a, b, res_v, exp_l, exp_r;
    logic [3:0]  exp_op;
    bit          legal, ldi, we;
    int          waited;
    opc = ins[15:12]; rd = ins[11:8]; rs1 = ins[7:4]; rs2 = ins[3:0]; imm = ins[7:0];
    a = (rs1 == 0) ? 16'h0 : m_rf[rs1];
    b = (rs2 == 0) ? 16'h0 : m_rf[rs2];
    ldi   = LDI_ON && opc == 4'h8;
    legal = (opc <= 4'h5) || ldi;
    exp_l  = ldi ? 16'h0 : a;
    exp_r  = ldi ? {8'h00, imm} : b;
    exp_op = !legal ? 4'h0 : (ldi ? 4'h1 : opc);
    case (opc)
      4'h1:    res_v = a + b;
      4'h2:    res_v = a - b;
      4'h3:    res_v = a & b;
      4'h4:    res_v = a | b;
      4'h5:    res_v = a ^ b;
      4'h8:    res_v = ldi ? {8'h00, imm} : 16'h0;
      default: res_v = 16'h0;
    endcase
    if (seed_en) res_v = seed_val;
    we = legal && opc != 4'h0 && rd != 4'h0;
    instr_in = ins;
    instr_valid = 1'b1;
    waited = 0;
    while (!instr_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_wait", waited, 0);
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) instr_valid = 1'b0;
    chk("exec_ready", instr_ready, 0);
    chk("exec_op", OP, exp_op);
    chk("exec_lbus", Lbus, exp_l);
    chk("exec_rbus", Rbus, exp_r);
    chk("exec_err", err, 0);
    @(negedge clk);
    chk("wb_ready", instr_ready, 0);
    chk("wb_op", OP, 0);
    chk("wb_en", wb_en, we);
    chk("wb_err", err, !legal);
    chk("wb_data", wb_data, res_v);
    if (we) chk("wb_addr", wb_addr, rd);
    if (we) m_rf[rd] = res_v;
    @(negedge clk);
    chk("idle_ready", instr_ready, 1);
    chk("idle_op", OP, 0);
    chk("idle_wb_en", wb_en, 0);
    chk("idle_err", err, 0);
    peek(rd, (rd == 0) ? 16'h0 : m_rf[rd], "rf_rd");
  endtask

  task automatic seed(input logic [3:0] rd, input logic [15:0] v);
    seed_en = 1'b1;
    seed_val = v;
    issue({4'h1, rd, 8'h00}, 1'b0);
    seed_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_op", OP, 0);
    chk("rst_lbus", Lbus, 0);
    chk("rst_rbus", Rbus, 0);
    chk("rst_ready", instr_ready, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_err", err, 0);
    res = 1'b1;
    #1;
    chk("post_rst_ready", instr_ready, 1);
    for (int i = 0; i < 16; i++) peek(i[3:0], 16'h0, "rst_rf");
    @(negedge clk);
    // Directed operand setup and arithmetic
    if (LDI_ON) begin
      issue(16'h8105, 1'b0);
      issue(16'h8203, 1'b0);
      issue(16'h1312, 1'b0);
      peek(4'd3, 16'h0008, "add_r3");
    end else begin
      seed(4'd1, 16'h0005);
      seed(4'd2, 16'h0003);
      issue(16'h8123, 1'b0);
      peek(4'd1, 16'h0005, "ldi_off_r1");
    end
    issue(16'h2421, 1'b0);
    peek(4'd4, 16'hFFFE, "sub_r4");
    issue(16'h5511, 1'b0);
    peek(4'd5, 16'h0000, "xor_r5");
    issue(16'h1012, 1'b0);
    peek(4'd0, 16'h0000, "add_r0");
    issue(16'hC712, 1'b0);
    peek(4'd7, 16'h0000, "illegal_r7");
    // Producer holding valid high back to back
    issue(16'h1612, 1'b1);
    issue(16'h4712, 1'b1);
    issue(16'h3814, 1'b1);
    instr_valid = 1'b0;
    // Reset during EXEC of ADD r6
    instr_in = 16'h1612;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_exec_op", OP, 1);
    res = 1'b0;
    instr_valid = 1'b0;
    #1;
    chk("mid_rst_op", OP, 0);
    chk("mid_rst_lbus", Lbus, 0);
    chk("mid_rst_ready", instr_ready, 0);
    for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
    @(negedge clk);
    res = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_mid_wb_en", wb_en, 0);
      chk("post_mid_err", err, 0);
      chk("post_mid_ready", instr_ready, 1);
      @(negedge clk);
    end
    peek(4'd6, 16'h0000, "mid_rst_r6");
    peek(4'd1, 16'h0000, "mid_rst_r1");
    @(negedge clk);
    // Random phase: seed every register, then random instruction mix
    for (int i = 1; i < 16; i++) seed(i[3:0], 16'($urandom));
    for (int n = 0; n < 200; n++) begin
      logic [3:0]  o;
      logic [11:0] f;
      o = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 5)) : 4'($urandom_range(0, 15));
      f = 12'($urandom);
      issue({o, f}, 1'($urandom_range(0, 1)));
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 16; i++) peek(i[3:0], (i == 0) ? 16'h0 : m_rf[i], "final_rf");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
